// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding and constants for the PWM duty meter.
package pwm_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;
  localparam int PCT_SCALE = 100;
  localparam int QUOT_W    = 7;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider producing a QUOT_W-bit quotient in QUOT_W cycles.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W+QUOT_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic [QUOT_W-1:0]       quotient
);
  localparam int NUM_W = CNT_W + QUOT_W;
  localparam int IT_W  = $clog2(QUOT_W + 1);
  localparam logic [IT_W-1:0] ITERS = IT_W'(QUOT_W);
  localparam logic [IT_W-1:0] IT_ONE = IT_W'(1);
  logic [NUM_W-1:0]  rem_q, den_q;
  logic [QUOT_W-2:0] quo_q;
  logic [IT_W-1:0]   it_q;
  logic              busy_q, ge;
  // Quotient is known to fit QUOT_W bits, so the divisor starts pre-shifted by QUOT_W-1.
  assign ge       = rem_q >= den_q;
  assign busy     = busy_q;
  assign done     = busy_q & (it_q == IT_ONE);
  assign quotient = {quo_q, ge};
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      it_q   <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start & (~busy_q | done)) begin
      rem_q  <= dividend;
      den_q  <= NUM_W'(divisor) << (QUOT_W - 1);
      quo_q  <= '0;
      it_q   <= ITERS;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= ge ? rem_q - den_q : rem_q;
      den_q  <= den_q >> 1;
      quo_q  <= quotient[QUOT_W-2:0];
      it_q   <= it_q - IT_ONE;
      busy_q <= ~done;
    end
  end
endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures PWM high time, period and duty percentage with stuck detection.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [QUOT_W-1:0] duty_pct,
  output logic              meas_valid,
  output logic              stuck_hi,
  output logic              stuck_lo
);
  localparam int NUM_W = CNT_W + QUOT_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, idle_q, high_lat_q, cap_high_q, cap_per_q;
  logic [CNT_W-1:0]  high_cnt_q, period_cnt_q;
  logic [QUOT_W-1:0] duty_q, div_quot;
  logic              meas_valid_q, stuck_hi_q, stuck_lo_q;
  logic              rise, fall, edge_det, timeout, start, lat_high, accept;
  logic              div_busy, div_done;
  logic [NUM_W-1:0]  dividend;
  assign rise       = sync2_q & ~prev_q;
  assign fall       = ~sync2_q & prev_q;
  assign edge_det   = rise | fall;
  assign timeout    = (idle_q == TO_LAST) & ~edge_det;
  assign accept     = start & (~div_busy | div_done);
  assign dividend   = NUM_W'(high_lat_q) * NUM_W'(PCT_SCALE);
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign duty_pct   = duty_q;
  assign meas_valid = meas_valid_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;
  always_comb begin
    lat_high = (state_q == S_HIGH) & fall;
    start    = (state_q == S_LOW) & rise;
    state_d  = timeout ? S_IDLE : (rise ? S_HIGH : (lat_high ? S_LOW : state_q));
  end
  // cnt_q holds cycles since the last rise, so it reads high time at a fall and period at a rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= '0;
      high_lat_q   <= '0;
      cap_high_q   <= '0;
      cap_per_q    <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      duty_q       <= '0;
      meas_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= pwm_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= rise ? ONE : (&cnt_q ? cnt_q : cnt_q + ONE);
      idle_q       <= edge_det ? '0 : (idle_q == TO_FULL ? idle_q : idle_q + ONE);
      meas_valid_q <= timeout | div_done;
      if (lat_high) high_lat_q <= cnt_q;
      if (accept) begin
        cap_high_q <= high_lat_q;
        cap_per_q  <= cnt_q;
      end
      if (timeout) begin
        stuck_hi_q   <= sync2_q;
        stuck_lo_q   <= ~sync2_q;
        duty_q       <= sync2_q ? QUOT_W'(PCT_SCALE) : '0;
        high_cnt_q   <= '0;
        period_cnt_q <= '0;
      end else begin
        if (edge_det) begin
          stuck_hi_q <= 1'b0;
          stuck_lo_q <= 1'b0;
        end
        if (div_done) begin
          high_cnt_q   <= cap_high_q;
          period_cnt_q <= cap_per_q;
          duty_q       <= div_quot;
        end
      end
    end
  end
  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (timeout),
    .dividend(dividend),
    .divisor (cnt_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: scoreboard bench for the PWM duty meter.
module tb_pwm_duty_meter;
  localparam int CNT_W = 16;
  typedef struct {
    int h;
    int p;
    int d;
    int sh;
    int sl;
  } exp_t;
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid, stuck_hi, stuck_lo;
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               t_rise2 = 0;
  exp_t             sb[$];
  int               mv_cyc[$];
  exp_t             e;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .duty_pct  (duty_pct),
    .meas_valid(meas_valid),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high_cnt"}, int'(high_cnt), 0);
    chk({tag, "_period_cnt"}, int'(period_cnt), 0);
    chk({tag, "_duty_pct"}, int'(duty_pct), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_stuck_hi"}, int'(stuck_hi), 0);
    chk({tag, "_stuck_lo"}, int'(stuck_lo), 0);
  endtask

  // One rise-to-rise period; m says whether a following rise will close and measure it.
  task automatic period(input int h, input int p, input bit m);
    if (m) sb.push_back('{h, p, (100 * h) / p, 0, 0});
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    pwm_in = 1'b0;
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      mv_cyc.push_back(cyc);
      if (sb.size() == 0) chk("spurious_meas_valid", int'(meas_valid), 0);
      else begin
        e = sb.pop_front();
        chk("sb_high_cnt", int'(high_cnt), e.h);
        chk("sb_period_cnt", int'(period_cnt), e.p);
        chk("sb_duty_pct", int'(duty_pct), e.d);
        chk("sb_stuck_hi", int'(stuck_hi), e.sh);
        chk("sb_stuck_lo", int'(stuck_lo), e.sl);
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    chk_zero("rst");
    do_reset(1);
    mv_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) t_rise2 = cyc;
      period(3, 10, 1'b1);
    end
    for (int h = 1; h <= 8; h++) repeat (2) period(h, 10, 1'b1);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("steady_pulse_count", mv_cyc.size(), 22);
    if (mv_cyc.size() >= 5) begin
      chk("first_latency", mv_cyc[0] - t_rise2, 10);
      chk("steady_spacing_a", mv_cyc[1] - mv_cyc[0], 10);
      chk("steady_spacing_b", mv_cyc[4] - mv_cyc[3], 10);
    end
    chk("sweep_final_duty", int'(duty_pct), 80);
    do_reset(2);
    period(1, 3, 1'b1);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("trunc_1_3", int'(duty_pct), 33);
    do_reset(2);
    period(2, 3, 1'b1);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("trunc_2_3", int'(duty_pct), 66);
    do_reset(2);
    mv_cyc.delete();
    for (int i = 0; i < 8; i++) period(2, 4, (i % 2) == 0);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("overrun_pulse_count", mv_cyc.size(), 4);
    if (mv_cyc.size() >= 4) begin
      chk("overrun_spacing_a", mv_cyc[1] - mv_cyc[0], 8);
      chk("overrun_spacing_b", mv_cyc[2] - mv_cyc[1], 8);
      chk("overrun_spacing_c", mv_cyc[3] - mv_cyc[2], 8);
    end
    chk("overrun_period", int'(period_cnt), 4);
    do_reset(2);
    period(3, 10, 1'b1);
    period(3, 10, 1'b0);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_duty", int'(duty_pct), 30);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("middiv_in_rst");
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (15) @(negedge clk);
    chk_zero("middiv_after");
    do_reset(2);
    sb.push_back('{0, 0, 100, 1, 0});
    pwm_in = 1'b1;
    repeat (1010) @(negedge clk);
    chk("stuck_hi_set", int'(stuck_hi), 1);
    chk("stuck_hi_duty", int'(duty_pct), 100);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("stuck_hi_clear", int'(stuck_hi), 0);
    repeat (3) period(5, 10, 1'b1);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("stuck_hi_resume_duty", int'(duty_pct), 50);
    do_reset(2);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    sb.push_back('{0, 0, 0, 0, 1});
    pwm_in = 1'b0;
    repeat (1010) @(negedge clk);
    chk("stuck_lo_set", int'(stuck_lo), 1);
    chk("stuck_lo_no_hi", int'(stuck_hi), 0);
    period(5, 10, 1'b1);
    chk("stuck_lo_clear", int'(stuck_lo), 0);
    period(5, 10, 1'b1);
    period(1, 12, 1'b0);
    repeat (5) @(negedge clk);
    chk("stuck_lo_resume_duty", int'(duty_pct), 50);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
